// File: rtl/demux_6_bit_reg_if.sv
// Bit-write / word-release bus for demux_6_bit_reg.
// Optional feature macro: DEMUX_AUTO_INC_EN adds the wr_auto strobe qualifier.
interface demux_6_bit_reg_if;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic        wr_bit;
  logic        commit;
  logic        wr_ready;
  logic        word_valid;
  logic        word_ready;
  logic [63:0] word_data;
  logic [63:0] written_mask;
`ifdef DEMUX_AUTO_INC_EN
  logic        wr_auto;

  // Producer/consumer side
  modport master (
    output wr_en, wr_addr, wr_bit, commit, word_ready, wr_auto,
    input  wr_ready, word_valid, word_data, written_mask
  );

  // Word assembler side
  modport slave (
    input  wr_en, wr_addr, wr_bit, commit, word_ready, wr_auto,
    output wr_ready, word_valid, word_data, written_mask
  );
`else
  // Producer/consumer side
  modport master (
    output wr_en, wr_addr, wr_bit, commit, word_ready,
    input  wr_ready, word_valid, word_data, written_mask
  );

  // Word assembler side
  modport slave (
    input  wr_en, wr_addr, wr_bit, commit, word_ready,
    output wr_ready, word_valid, word_data, written_mask
  );
`endif
endinterface

// File: rtl/demux_6_bit_reg.sv
// Scatters single bits into a 64-bit word at a 6-bit index, tracks written
// positions, and releases the word over valid/ready when complete or committed.
// Optional feature macro: DEMUX_AUTO_INC_EN (auto-incrementing write pointer).
module demux_6_bit_reg #(
  parameter logic FILL_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  demux_6_bit_reg_if.slave  bus
);

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned WORD_W = 64;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [WORD_W-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0]   wr_idx_c;
`ifdef DEMUX_AUTO_INC_EN
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
`endif

  // Next-state: accept writes/commit in FILL, wait for consumer in HOLD
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mask_d   = mask_q;
    wr_idx_c = bus.wr_addr;
`ifdef DEMUX_AUTO_INC_EN
    ptr_d    = ptr_q;
    if (bus.wr_auto) begin
      wr_idx_c = ptr_q;
    end
`endif
    case (state_q)
      ST_FILL: begin
        if (bus.wr_en) begin
          data_d[wr_idx_c] = bus.wr_bit;
          mask_d[wr_idx_c] = 1'b1;
`ifdef DEMUX_AUTO_INC_EN
          if (bus.wr_auto) begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
`endif
        end
        // Completion includes this cycle's write, so a write+commit keeps the bit
        if (bus.commit || (&mask_d)) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.word_ready) begin
          state_d = ST_FILL;
          data_d  = {WORD_W{FILL_VAL}};
          mask_d  = '0;
`ifdef DEMUX_AUTO_INC_EN
          ptr_d   = '0;
`endif
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any held word
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
      data_q  <= {WORD_W{FILL_VAL}};
      mask_q  <= '0;
`ifdef DEMUX_AUTO_INC_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
`ifdef DEMUX_AUTO_INC_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.wr_ready     = (state_q == ST_FILL);
  assign bus.word_valid   = (state_q == ST_HOLD);
  assign bus.word_data    = data_q;
  assign bus.written_mask = mask_q;

endmodule

// File: tb/tb_demux_6_bit_reg.sv
// Randomized scoreboard bench for demux_6_bit_reg.
// Build with +define+DEMUX_AUTO_INC_EN to also exercise the auto-increment pointer.
module tb_demux_6_bit_reg;

  localparam logic TB_FILL = 1'b0;
  localparam logic [63:0] FILL_WORD = {64{TB_FILL}};

  typedef struct packed {
    logic [63:0] data;
    logic [63:0] mask;
  } word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  demux_6_bit_reg_if bus ();

  demux_6_bit_reg #(.FILL_VAL(TB_FILL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: the word being assembled, which positions are filled,
  // whether a word is waiting for the consumer, and released words in order
  logic [63:0] m_data = FILL_WORD;
  logic [63:0] m_mask = '0;
  bit          m_hold = 1'b0;
  logic [5:0]  m_ptr  = '0;
  word_t       sb[$];
  word_t       sb_e;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check visible state at negedge, then advance the model
  task automatic cycle(input logic en, input logic [5:0] addr, input logic b,
                       input logic com, input logic rdy, input logic rst,
                       input logic au);
    int idx;
    reset          = rst;
    bus.wr_en      = en;
    bus.wr_addr    = addr;
    bus.wr_bit     = b;
    bus.commit     = com;
    bus.word_ready = rdy;
`ifdef DEMUX_AUTO_INC_EN
    bus.wr_auto    = au;
`endif
    @(negedge clk);
    chk("wr_ready",     64'(bus.wr_ready),   64'(!m_hold));
    chk("word_valid",   64'(bus.word_valid), 64'(m_hold));
    chk("word_data",    bus.word_data,       m_data);
    chk("written_mask", bus.written_mask,    m_mask);
    @(posedge clk);
    if (rst) begin
      m_data = FILL_WORD;
      m_mask = '0;
      m_hold = 1'b0;
      m_ptr  = '0;
      sb.delete();
    end else if (!m_hold) begin
      if (en) begin
        idx = int'(addr);
        if (au) begin
          idx   = int'(m_ptr);
          m_ptr = 6'((int'(m_ptr) + 1) % 64);
        end
        m_data[idx] = b;
        m_mask[idx] = 1'b1;
      end
      if (com || m_mask == {64{1'b1}}) begin
        m_hold = 1'b1;
        sb.push_back('{data: m_data, mask: m_mask});
      end
    end else if (rdy) begin
      m_hold = 1'b0;
      m_data = FILL_WORD;
      m_mask = '0;
      m_ptr  = '0;
    end
    #2;
  endtask

  task automatic wr(input logic [5:0] addr, input logic b, input logic com);
    cycle(1'b1, addr, b, com, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 6'd0, 1'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every accepted word must match the oldest released word
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_underflow: got handshake with data %h, expected none", bus.word_data);
      end else begin
        sb_e = sb.pop_front();
        chk("sb_data", bus.word_data,    sb_e.data);
        chk("sb_mask", bus.written_mask, sb_e.mask);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] pat;
    logic [63:0] snap;
    logic        b63;

    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_bit     = 1'b0;
    bus.commit     = 1'b0;
    bus.word_ready = 1'b0;
`ifdef DEMUX_AUTO_INC_EN
    bus.wr_auto    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #2;

    // Reset with write and commit present: both dropped
    cycle(1'b1, 6'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("rst_valid", 64'(bus.word_valid), 64'(0));
    chk("rst_mask",  bus.written_mask,    64'(0));

    // T1: ascending fill of ones releases on the last write
    for (int i = 0; i < 64; i++) begin
      wr(6'(i), 1'b1, 1'b0);
      if (i == 62) chk("t1_no_early", 64'(bus.word_valid), 64'(0));
    end
    chk("t1_valid", 64'(bus.word_valid), 64'(1));
    chk("t1_data",  bus.word_data,       {64{1'b1}});
    chk("t1_mask",  bus.written_mask,    {64{1'b1}});
    idle(1'b1);

    // T2: rewrite same index, then commit
    wr(6'd5, 1'b1, 1'b0);
    wr(6'd5, 1'b0, 1'b0);
    chk("t2_no_early", 64'(bus.word_valid), 64'(0));
    cycle(1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_valid", 64'(bus.word_valid), 64'(1));
    chk("t2_data",  bus.word_data,       64'(0));
    chk("t2_mask",  bus.written_mask,    64'h20);

    // T3: consumer stalls 10 cycles while producer keeps poking
    snap = bus.word_data;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 6'($urandom_range(63)), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("t3_stable", bus.word_data,     snap);
    chk("t3_ready",  64'(bus.wr_ready), 64'(0));
    idle(1'b1);
    chk("t3_rel_data",  bus.word_data,     64'(0));
    chk("t3_rel_mask",  bus.written_mask,  64'(0));
    chk("t3_rel_ready", 64'(bus.wr_ready), 64'(1));

    // T4: final write coincides with commit
    for (int i = 0; i < 63; i++) wr(6'(i), 1'($urandom_range(1)), 1'b0);
    b63 = 1'($urandom_range(1));
    wr(6'd63, b63, 1'b1);
    chk("t4_bit63", 64'(bus.word_data[63]), 64'(b63));
    chk("t4_mask",  bus.written_mask,       {64{1'b1}});
    idle(1'b1);
    idle(1'b1);
    chk("t4_single", 64'(bus.word_valid), 64'(0));

    // Empty commit releases the fill word
    cycle(1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("empty_valid", 64'(bus.word_valid), 64'(1));
    chk("empty_data",  bus.word_data,       FILL_WORD);
    idle(1'b1);

    // T5: reset while holding a word discards it
    pat = 64'hDEAD_BEEF_0000_FFFF;
    for (int i = 0; i < 64; i++) wr(6'(i), pat[i], 1'b0);
    chk("t5_data", bus.word_data, pat);
    cycle(1'b1, 6'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t5_valid", 64'(bus.word_valid), 64'(0));
    chk("t5_data0", bus.word_data,       64'(0));
    chk("t5_mask0", bus.written_mask,    64'(0));

`ifdef DEMUX_AUTO_INC_EN
    // T6: 64 auto writes alternate 1,0 from bit 0
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 6'($urandom_range(63)), 1'((i + 1) % 2), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("t6_data",  bus.word_data,       64'h5555_5555_5555_5555);
    chk("t6_valid", 64'(bus.word_valid), 64'(1));
    idle(1'b1);
    // Pointer restarts at 0; an explicit-address write leaves it alone
    wr(6'd40, 1'b1, 1'b0);
    cycle(1'b1, 6'd17, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_ptr0", bus.word_data, 64'h0000_0100_0000_0001);
    idle(1'b1);
`endif

    // Randomized traffic including stalls, commits and occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic au;
`ifdef DEMUX_AUTO_INC_EN
      au = 1'($urandom_range(3) == 0);
`else
      au = 1'b0;
`endif
      cycle(1'($urandom_range(1)), 6'($urandom_range(63)), 1'($urandom_range(1)),
            1'($urandom_range(39) == 0), 1'($urandom_range(1)),
            1'($urandom_range(199) == 0), au);
    end

    repeat (3) idle(1'b1);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
